// File: rtl/ram_pkg.sv
// ram_pkg
//   Shared definitions for the cache-line RAM sequencer.
//   - Default geometry: RAM word-address width, word width, words per line,
//     read latency, and the derived offset / line-address widths.
//   - line_state_e: sequencer state encoding (IDLE, WR, RD, DRAIN, FIN).
package ram_pkg;

    localparam int DEF_ADDR_W     = 9;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LINE_WORDS = 8;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_OFF_W      = $clog2(DEF_LINE_WORDS);
    localparam int DEF_LA_W       = DEF_ADDR_W - DEF_OFF_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } line_state_e;

endpackage

// File: rtl/ram_rd_token_pipe.sv
// ram_rd_token_pipe
//   DEPTH-stage shift register carrying {valid, word index} tokens for reads
//   in flight. A token pushed in the ram_en cycle of a read reaches the last
//   stage exactly DEPTH cycles later, i.e. in the cycle the RAM data is valid.
// Ports:
//   clk, rst         clock, synchronous active-high flush
//   push, push_idx   token entering the pipe this cycle
//   out_valid        token present in the last stage
//   out_idx          word index of that token
//   busy             any stage holds a valid token
module ram_rd_token_pipe
    import ram_pkg::*;
#(
    parameter int DEPTH = DEF_RD_LAT,
    parameter int IDX_W = DEF_OFF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy
);

    logic [DEPTH-1:0] vld_r;
    logic [IDX_W-1:0] idx_r [DEPTH];

    // Token shift register, flushed on reset so aborted reads never emerge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                idx_r[i] <= {IDX_W{1'b0}};
            end
        end else begin
            vld_r[0] <= push;
            idx_r[0] <= push_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_r[i] <= vld_r[i-1];
                idx_r[i] <= idx_r[i-1];
            end
        end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_idx   = idx_r[DEPTH-1];
    assign busy      = |vld_r;

endmodule

// File: rtl/ram_line_seq.sv
// ram_line_seq
//   Turns one cache-line request (fill or write-back) into LINE_WORDS
//   single-word accesses on a word-wide RAM with an ram_en/ram_rdy handshake.
//   Fill words stream back with their index; done pulses once per line.
//   Optional build macro RAM_LINE_SEQ_STATS_EN adds fill / write-back
//   completion counters on stat_fills / stat_wbacks (tied to 0 otherwise).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           line request handshake
//   req_write, req_line           1 = write-back, 0 = fill; line address
//   wr_valid, wr_data, wr_ready   write-back word stream (index order)
//   rd_valid, rd_data, rd_idx     fill word return (no backpressure)
//   done                          one-cycle pulse at line completion
//   ram_addr, data_to_ram,
//   ram_en, ram_write             RAM request side
//   ram_rdy, data_from_ram        RAM response side
//   stat_fills, stat_wbacks       completed-line counters
module ram_line_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int LA_W       = ADDR_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [LA_W-1:0]   req_line,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [OFF_W-1:0]  rd_idx,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] data_to_ram,
    output logic              ram_en,
    output logic              ram_write,
    input  logic              ram_rdy,
    input  logic [DATA_W-1:0] data_from_ram,
    output logic [31:0]       stat_fills,
    output logic [31:0]       stat_wbacks
);

    localparam logic [OFF_W-1:0] IDX_ONE  = OFF_W'(1);
    localparam logic [OFF_W-1:0] IDX_LAST = OFF_W'(LINE_WORDS - 1);

    line_state_e       state_r;
    logic [LA_W-1:0]   line_r;
    logic              write_r;
    logic [OFF_W-1:0]  idx_r;
    logic              gap_r;
    logic              req_ready_r;
    logic              rd_valid_r;
    logic [DATA_W-1:0] rd_data_r;
    logic [OFF_W-1:0]  rd_idx_r;
    logic              done_r;

    logic              issue_s;
    logic              last_s;
    logic              pipe_vld_s;
    logic [OFF_W-1:0]  pipe_idx_s;
    logic              pipe_busy_s;

    // Issue decision: the RAM must be ready in this very cycle, so the
    // enable is decoded from registered state plus the live handshake
    // inputs. gap_r forces an idle cycle after every enable.
    always_comb begin
        issue_s = 1'b0;
        if (rst) begin
            issue_s = 1'b0;
        end else begin
            case (state_r)
                WR:      issue_s = ram_rdy && wr_valid && !gap_r;
                RD:      issue_s = ram_rdy && !gap_r;
                default: issue_s = 1'b0;
            endcase
        end
    end

    assign last_s      = (idx_r == IDX_LAST);
    assign ram_en      = issue_s;
    assign ram_write   = issue_s && (state_r == WR);
    assign wr_ready    = ram_write;
    assign ram_addr    = {line_r, idx_r};
    assign data_to_ram = (!rst && (state_r == WR)) ? wr_data : {DATA_W{1'b0}};

    assign req_ready   = req_ready_r;
    assign rd_valid    = rd_valid_r;
    assign rd_data     = rd_data_r;
    assign rd_idx      = rd_idx_r;
    assign done        = done_r;

    ram_rd_token_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (OFF_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_s && (state_r == RD)),
        .push_idx  (idx_r),
        .out_valid (pipe_vld_s),
        .out_idx   (pipe_idx_s),
        .busy      (pipe_busy_s)
    );

    // Line sequencer FSM with registered request/return/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            line_r      <= {LA_W{1'b0}};
            write_r     <= 1'b0;
            idx_r       <= {OFF_W{1'b0}};
            gap_r       <= 1'b0;
            req_ready_r <= 1'b1;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= {DATA_W{1'b0}};
            rd_idx_r    <= {OFF_W{1'b0}};
            done_r      <= 1'b0;
        end else begin
            gap_r      <= issue_s;
            done_r     <= 1'b0;
            // The token leaves the pipe in the cycle the RAM data is valid.
            rd_valid_r <= pipe_vld_s;
            if (pipe_vld_s) begin
                rd_data_r <= data_from_ram;
                rd_idx_r  <= pipe_idx_s;
            end
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        line_r      <= req_line;
                        write_r     <= req_write;
                        idx_r       <= {OFF_W{1'b0}};
                        req_ready_r <= 1'b0;
                        state_r     <= req_write ? WR : RD;
                    end
                end
                WR: begin
                    if (issue_s) begin
                        idx_r <= idx_r + IDX_ONE;
                        if (last_s) begin
                            state_r <= FIN;
                            done_r  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (issue_s) begin
                        idx_r <= idx_r + IDX_ONE;
                        if (last_s) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // busy covers the last stage, so an empty pipe means
                    // the final word has already been captured for return.
                    if (!pipe_busy_s) begin
                        state_r <= FIN;
                        done_r  <= 1'b1;
                    end
                end
                FIN: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef RAM_LINE_SEQ_STATS_EN
    logic [31:0] stat_fills_r;
    logic [31:0] stat_wbacks_r;

    // Completed-line counters, bumped in the done cycle by request type.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fills_r  <= 32'd0;
            stat_wbacks_r <= 32'd0;
        end else if (done_r) begin
            if (write_r) begin
                stat_wbacks_r <= stat_wbacks_r + 32'd1;
            end else begin
                stat_fills_r <= stat_fills_r + 32'd1;
            end
        end
    end

    assign stat_fills  = stat_fills_r;
    assign stat_wbacks = stat_wbacks_r;
`else
    assign stat_fills  = 32'd0;
    assign stat_wbacks = 32'd0;
`endif

endmodule

// File: tb/tb_ram_line_seq.sv
// tb_ram_line_seq
//   Self-checking bench for ram_line_seq: a behavioural RAM, a reference
//   memory image updated per accepted request, and a negedge scoreboard
//   monitor comparing every RAM access, returned word and done pulse.
module tb_ram_line_seq;
    import ram_pkg::*;

    localparam int ADDR_W     = DEF_ADDR_W;
    localparam int DATA_W     = DEF_DATA_W;
    localparam int LINE_WORDS = DEF_LINE_WORDS;
    localparam int RD_LAT     = DEF_RD_LAT;
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int LA_W       = ADDR_W - OFF_W;
    localparam int MEM_N      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [LA_W-1:0]   req_line = '0;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [OFF_W-1:0]  rd_idx;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] data_to_ram;
    logic              ram_en;
    logic              ram_write;
    logic              ram_rdy = 1'b0;
    logic [DATA_W-1:0] data_from_ram;
    logic [31:0]       stat_fills;
    logic [31:0]       stat_wbacks;

    always #5 clk = ~clk;

    ram_line_seq dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_line      (req_line),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_idx        (rd_idx),
        .done          (done),
        .ram_addr      (ram_addr),
        .data_to_ram   (data_to_ram),
        .ram_en        (ram_en),
        .ram_write     (ram_write),
        .ram_rdy       (ram_rdy),
        .data_from_ram (data_from_ram),
        .stat_fills    (stat_fills),
        .stat_wbacks   (stat_wbacks)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Power-up RAM contents; line 5 holds A000_0000+i.
    function automatic logic [31:0] init_word(input int a);
        if (a >= 40 && a < 48) return 32'hA000_0000 + 32'(a - 40);
        else return 32'h5A5A_0000 ^ 32'(a);
    endfunction

    // ---------------- behavioural RAM (environment) ----------------
    logic [DATA_W-1:0] ram_mem [MEM_N];
    bit                ram_wr  [MEM_N];
    logic [DATA_W-1:0] rdpipe  [RD_LAT];

    always @(posedge clk) begin
        if (ram_en && ram_write) begin
            ram_mem[ram_addr] <= data_to_ram;
            ram_wr[ram_addr]  <= 1'b1;
        end
        rdpipe[0] <= (ram_en && !ram_write)
                     ? (ram_wr[ram_addr] ? ram_mem[ram_addr] : init_word(int'(ram_addr)))
                     : 32'hDEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) rdpipe[i] <= rdpipe[i-1];
    end
    assign data_from_ram = rdpipe[RD_LAT-1];

    // ---------------- reference model state ----------------
    logic [DATA_W-1:0] ref_mem [MEM_N];
    bit                ref_wr  [MEM_N];
    logic [DATA_W-1:0] exp_rd_data[$];
    int                exp_rd_idx[$];
    int                exp_raddr[$];
    int                exp_waddr[$];
    logic [DATA_W-1:0] exp_wdata[$];
    bit                exp_done[$];
    logic [DATA_W-1:0] wsrc[$];
    logic [DATA_W-1:0] next_wdata [LINE_WORDS];
    int                issue_cyc[$];
    int  model_fills = 0, model_wbacks = 0;
    int  done_cnt = 0, issue_cnt = 0, cyc = 0;
    bit  busy_m = 0, prev_en = 0, prev_done = 0;
    bit  rdy_force_low = 0, rdy_rand = 0, wv_toggle = 0, wv_phase = 0;

    function automatic logic [DATA_W-1:0] ref_read(input int a);
        return ref_wr[a] ? ref_mem[a] : init_word(a);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Input supply: ram_rdy pattern and the write-back word stream.
    always @(posedge clk) begin
        #2;
        ram_rdy = rdy_force_low ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (wsrc.size() > 0) begin
            wr_data  = wsrc[0];
            wr_valid = wv_toggle ? wv_phase : ($urandom_range(0, 2) != 0);
        end else begin
            wr_data  = '0;
            wr_valid = 1'b0;
        end
        wv_phase = !wv_phase;
    end

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy_m) chk(!req_ready, "ready_low_busy", 64'(req_ready), 64'd0);
            if (prev_done) chk(req_ready, "ready_after_done", 64'(req_ready), 64'd1);
            if (req_valid && req_ready) begin
                int base;
                chk(!busy_m, "accept_idle", 64'(busy_m), 64'd0);
                busy_m = 1;
                base = int'(req_line) * LINE_WORDS;
                for (int i = 0; i < LINE_WORDS; i++) begin
                    if (req_write) begin
                        exp_waddr.push_back(base + i);
                        exp_wdata.push_back(next_wdata[i]);
                        wsrc.push_back(next_wdata[i]);
                        ref_mem[base + i] = next_wdata[i];
                        ref_wr[base + i]  = 1'b1;
                    end else begin
                        exp_raddr.push_back(base + i);
                        exp_rd_data.push_back(ref_read(base + i));
                        exp_rd_idx.push_back(i);
                    end
                end
                exp_done.push_back(req_write);
            end
            if (ram_en) begin
                chk(ram_rdy, "en_needs_rdy", 64'(ram_rdy), 64'd1);
                chk(!prev_en, "en_spacing", 64'(prev_en), 64'd0);
                if (ram_write) begin
                    if (exp_waddr.size() == 0) chk(1'b0, "unexpected_write", 64'(ram_addr), 64'd0);
                    else begin
                        int a;
                        logic [DATA_W-1:0] d;
                        a = exp_waddr.pop_front();
                        d = exp_wdata.pop_front();
                        chk(int'(ram_addr) == a, "wr_addr", 64'(ram_addr), 64'(a));
                        chk(data_to_ram == d, "wr_data", 64'(data_to_ram), 64'(d));
                    end
                end else begin
                    if (exp_raddr.size() == 0) chk(1'b0, "unexpected_read", 64'(ram_addr), 64'd0);
                    else begin
                        int a;
                        a = exp_raddr.pop_front();
                        chk(int'(ram_addr) == a, "rd_addr", 64'(ram_addr), 64'(a));
                    end
                    issue_cnt++;
                    issue_cyc.push_back(cyc);
                end
            end
            if (wr_ready) begin
                chk(ram_en && ram_write, "wr_ready_with_en", 64'(ram_en), 64'd1);
                if (wsrc.size() > 0) void'(wsrc.pop_front());
            end
            if (rd_valid) begin
                if (exp_rd_data.size() == 0) chk(1'b0, "unexpected_rd", 64'(rd_data), 64'd0);
                else begin
                    logic [DATA_W-1:0] d;
                    int ix;
                    d  = exp_rd_data.pop_front();
                    ix = exp_rd_idx.pop_front();
                    chk(rd_data == d, "rd_data", 64'(rd_data), 64'(d));
                    chk(int'(rd_idx) == ix, "rd_idx", 64'(rd_idx), 64'(ix));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk(1'b0, "unexpected_done", 64'd1, 64'd0);
                else begin
                    bit w;
                    w = exp_done.pop_front();
                    chk(exp_rd_data.size() == 0 && exp_waddr.size() == 0, "done_line_complete",
                        64'(exp_rd_data.size() + exp_waddr.size()), 64'd0);
                    if (w) model_wbacks++;
                    else model_fills++;
                end
                busy_m = 0;
                done_cnt++;
            end
            prev_en   = ram_en;
            prev_done = done;
        end else begin
            prev_en   = 1'b0;
            prev_done = 1'b0;
        end
    end

    // One-cycle synchronous reset; discards everything still expected.
    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk(!ram_en, "rst_en_off", 64'(ram_en), 64'd0);
        exp_rd_data.delete(); exp_rd_idx.delete(); exp_raddr.delete();
        exp_waddr.delete(); exp_wdata.delete(); exp_done.delete(); wsrc.delete();
        busy_m = 0; model_fills = 0; model_wbacks = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk(req_ready, "rst_ready", 64'(req_ready), 64'd1);
        chk(!ram_en, "rst_en_after", 64'(ram_en), 64'd0);
    endtask

    task automatic request(input bit wr, input logic [LA_W-1:0] line);
        int t;
        t = 0;
        @(posedge clk); #2;
        req_valid = 1'b1; req_write = wr; req_line = line;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            t++;
            if (t > 200) begin chk(1'b0, "accept_timeout", 64'd0, 64'd1); break; end
        end
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int t;
        t = 0;
        while (done_cnt < target && t < budget) begin @(posedge clk); t++; end
        chk(done_cnt >= target, "done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic wait_issues(input int target, input int budget);
        int t;
        t = 0;
        while (issue_cnt < target && t < budget) begin @(negedge clk); t++; end
        chk(issue_cnt >= target, "issue_timeout", 64'(issue_cnt), 64'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s0;
        bit wrs [3];
        wrs[0] = 1'b0; wrs[1] = 1'b1; wrs[2] = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();
        chk(rd_valid == 1'b0 && done == 1'b0 && ram_write == 1'b0 && wr_ready == 1'b0,
            "rst_ctrl", 64'({rd_valid, done, ram_write, wr_ready}), 64'd0);
        chk(ram_addr == '0 && data_to_ram == '0, "rst_ram_bus", 64'(ram_addr), 64'd0);
        chk(rd_data == '0 && rd_idx == '0, "rst_rd_bus", 64'(rd_data), 64'd0);

        // 1: fill of line 5 with RAM always ready -> strictly alternate enables.
        issue_cyc.delete();
        request(1'b0, 6'h05);
        wait_done(1, 200);
        chk(issue_cyc.size() == LINE_WORDS, "fill_issue_count", 64'(issue_cyc.size()), 64'(LINE_WORDS));
        if (issue_cyc.size() == LINE_WORDS)
            chk(issue_cyc[LINE_WORDS-1] - issue_cyc[0] == 2 * (LINE_WORDS - 1), "fill_alternate",
                64'(issue_cyc[LINE_WORDS-1] - issue_cyc[0]), 64'(2 * (LINE_WORDS - 1)));

        // 2: write-back of line 3F with toggling wr_valid, then read it back.
        for (int i = 0; i < LINE_WORDS; i++) next_wdata[i] = 32'hB0 + 32'(i);
        wv_toggle = 1'b1;
        request(1'b1, 6'h3F);
        wait_done(2, 300);
        wv_toggle = 1'b0;
        request(1'b0, 6'h3F);
        wait_done(3, 200);

        // 3: ram_rdy low for 5 cycles after word 3 of a fill.
        s0 = issue_cnt;
        request(1'b0, LA_W'($urandom_range(0, 63)));
        wait_issues(s0 + 4, 100);
        rdy_force_low = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        chk(issue_cnt == s0 + 4, "stall_no_issue", 64'(issue_cnt), 64'(s0 + 4));
        rdy_force_low = 1'b0;
        wait_done(4, 200);

        // 4: reset two cycles after the third read issue.
        s0 = issue_cnt;
        request(1'b0, LA_W'($urandom_range(0, 63)));
        wait_issues(s0 + 3, 100);
        @(posedge clk);
        d0 = done_cnt;
        do_reset();
        repeat (12) @(posedge clk);
        chk(done_cnt == d0, "no_done_after_rst", 64'(done_cnt), 64'(d0));
        request(1'b0, LA_W'($urandom_range(0, 63)));
        wait_done(d0 + 1, 200);

        // 5: back-to-back requests (fill, write-back, fill) with random stalls.
        do_reset();
        rdy_rand = 1'b1;
        d0 = done_cnt;
        begin
            int k, t;
            k = 0; t = 0;
            @(posedge clk); #2;
            req_valid = 1'b1; req_write = wrs[0]; req_line = LA_W'($urandom_range(0, 63));
            while (k < 3 && t < 3000) begin
                @(negedge clk);
                t++;
                if (req_ready) begin
                    k++;
                    @(posedge clk); #2;
                    if (k < 3) begin
                        req_write = wrs[k];
                        req_line  = LA_W'($urandom_range(0, 63));
                        for (int i = 0; i < LINE_WORDS; i++) next_wdata[i] = $urandom;
                    end else begin
                        req_valid = 1'b0;
                    end
                end
            end
            chk(k == 3, "b2b_accepts", 64'(k), 64'd3);
        end
        wait_done(d0 + 3, 1000);
        rdy_rand = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(exp_done.size() == 0 && exp_rd_data.size() == 0, "all_drained",
            64'(exp_done.size() + exp_rd_data.size()), 64'd0);
`ifdef RAM_LINE_SEQ_STATS_EN
        chk(stat_fills == 32'(model_fills) && model_fills == 2, "stat_fills", 64'(stat_fills), 64'd2);
        chk(stat_wbacks == 32'(model_wbacks) && model_wbacks == 1, "stat_wbacks", 64'(stat_wbacks), 64'd1);
`else
        chk(stat_fills == 32'd0, "stat_fills_tied", 64'(stat_fills), 64'd0);
        chk(stat_wbacks == 32'd0, "stat_wbacks_tied", 64'(stat_wbacks), 64'd0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
